// File: rtl/mux_demux_unit.sv
// Registered 2:1 mux lane and 1:2 demux lane sharing clock and reset.
// Each lane has one cycle of latency and its own valid qualifier.
module mux_demux_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel_mux,
    input  logic             mux_valid_in,
    output logic [WIDTH-1:0] y,
    output logic             mux_valid_out,
    input  logic [WIDTH-1:0] din,
    input  logic             sel_demux,
    input  logic             demux_valid_in,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic             mv_q, mv_d;
    logic             v0_q, v0_d;
    logic             v1_q, v1_d;

    // Mux lane: data holds when idle, valid is a single-cycle strobe.
    always_comb begin
        y_d  = y_q;
        mv_d = 1'b0;
        if (mux_valid_in) begin
            y_d  = sel_mux ? b : a;
            mv_d = 1'b1;
        end
    end

    // Demux lane: the unselected sink is cleared so it never shows stale data.
    always_comb begin
        y0_d = y0_q;
        y1_d = y1_q;
        v0_d = 1'b0;
        v1_d = 1'b0;
        if (demux_valid_in) begin
            if (sel_demux) begin
                y0_d = '0;
                y1_d = din;
                v1_d = 1'b1;
            end else begin
                y0_d = din;
                y1_d = '0;
                v0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            y0_q <= '0;
            y1_q <= '0;
            mv_q <= 1'b0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
            mv_q <= mv_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign y             = y_q;
    assign mux_valid_out = mv_q;
    assign y0            = y0_q;
    assign y1            = y1_q;
    assign y0_valid      = v0_q;
    assign y1_valid      = v1_q;

endmodule

// File: tb/tb_mux_demux_unit.sv
// Randomized and directed bench for mux_demux_unit, compared each cycle
// against a behavioural model of the steering rules.
module tb_mux_demux_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, din;
    logic         sel_mux, mux_valid_in, sel_demux, demux_valid_in;
    logic [W-1:0] y, y0, y1;
    logic         mux_valid_out, y0_valid, y1_valid;

    int n_pass = 0;
    int n_total = 0;

    // Expected output state
    logic [W-1:0] e_y, e_y0, e_y1;
    logic         e_mv, e_v0, e_v1;

    mux_demux_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .sel_mux       (sel_mux),
        .mux_valid_in  (mux_valid_in),
        .y             (y),
        .mux_valid_out (mux_valid_out),
        .din           (din),
        .sel_demux     (sel_demux),
        .demux_valid_in(demux_valid_in),
        .y0            (y0),
        .y1            (y1),
        .y0_valid      (y0_valid),
        .y1_valid      (y1_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".y"},   y, e_y);
        check_eq({tag, ".mv"},  W'(mux_valid_out), W'(e_mv));
        check_eq({tag, ".y0"},  y0, e_y0);
        check_eq({tag, ".y1"},  y1, e_y1);
        check_eq({tag, ".v0"},  W'(y0_valid), W'(e_v0));
        check_eq({tag, ".v1"},  W'(y1_valid), W'(e_v1));
        check_eq({tag, ".excl"}, W'(y0_valid & y1_valid), W'(0));
    endtask

    task automatic model_reset();
        e_y = '0; e_y0 = '0; e_y1 = '0;
        e_mv = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
    endtask

    // One rising edge as seen from the outside: the muxed source or the
    // routed input lands on the chosen sink; idle lanes keep data, drop valid.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        e_mv = mux_valid_in;
        if (mux_valid_in) e_y = (sel_mux == 1'b0) ? a : b;
        e_v0 = demux_valid_in && !sel_demux;
        e_v1 = demux_valid_in &&  sel_demux;
        if (demux_valid_in) begin
            e_y0 = e_v0 ? din : W'(0);
            e_y1 = e_v1 ? din : W'(0);
        end
    endtask

    // Inputs are changed only #1 after an edge, so at this point they are
    // still the values the edge sampled.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm, input logic mv,
                         input logic [W-1:0] id, input logic sd, input logic dv);
        a = ia; b = ib; sel_mux = sm; mux_valid_in = mv;
        din = id; sel_demux = sd; demux_valid_in = dv;
    endtask

    initial begin
        // Asynchronous reset with every input active, checked before any edge
        rst = 1'b1;
        drive(8'h01, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        #3;
        model_reset();
        check_all("rst_async");
        step("rst_hold");
        rst = 1'b0;

        // Mux select
        drive(8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("mux_a");
        drive(8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        step("mux_b");
        drive(8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("mux_hold");

        // Demux routing
        drive(8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        step("dmx_y0");
        drive(8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1);
        step("dmx_y1");

        // Full-rate toggling on both lanes
        for (int i = 0; i < 6; i++) begin
            drive(8'hA5, 8'h5A, i[0], 1'b1, 8'h3C, i[0], 1'b1);
            step($sformatf("toggle%0d", i));
        end

        // Demux hold with din changing
        drive(8'hA5, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("dmx_hold");
        drive(8'hA5, 8'h5A, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        step("sel_no_valid");

        // Mid-stream reset pulse between edges
        drive(8'h11, 8'h22, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
        step("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        #1 rst = 1'b0;
        drive(8'h44, 8'h55, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
        step("post_rst");

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 39) == 0) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                rst = 1'b0;
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
